pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and fetch-sequencing stage of the single-cycle MIPS datapath, sitting directly upstream of the instruction memory. Holds the architectural PC, drives it as the instruction-memory address, and computes the next PC each cycle from the returned instruction word and the branch/jump controls. Also provides halt on `syscall`, a sticky fetch fault for illegal targets, and a retired-instruction counter.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `MEM_WORDS`, 256, instruction-memory depth in words; legal PCs are 0 .. MEM_WORDS*4-4.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instruction`  in  32  word returned combinationally by instruction memory for the current `pc`.
- `branch`  in  1  branch taken (branch control AND ALU zero), current instruction.
- `jump`  in  1  `j`/`jal` of current instruction.
- `jr`  in  1  `jr` of current instruction.
- `rs_data`  in  32  register-file rs value, target for `jr`.
- `stall`  in  1  hold PC and counter this cycle.
- `pc`  out  32  current PC, drives instruction-memory address.
- `pc_plus4`  out  32  `pc + 4`, combinational (link value for `jal`).
- `halted`  out  1  high in HALT state.
- `fault`  out  1  high in FAULT state.
- `instr_count`  out  32  instructions retired since reset.

## Operation

- States: RUN, HALT, FAULT. Reset enters RUN.
- Target computation, combinational, all modulo 2^32:
  - seq = `pc + 4`.
  - branch target = `pc + 4 + (sign_extend(instruction[15:0]) << 2)`.
  - jump target = `{pc_plus4[31:28], instruction[25:0], 2'b00}`.
  - jr target = `rs_data`.
- Next-PC priority: `jr` > `jump` > `branch` > seq.
- Halt instruction: `instruction == 32'h0000_000C` (`syscall`). It overrides all control inputs.
- RUN, `stall`=1: PC, counter and state hold.
- RUN, `stall`=0, `syscall`: PC holds, counter +1, go to HALT.
- RUN, `stall`=0, selected next PC illegal (bits[1:0] != 0, or >= MEM_WORDS*4): PC holds, counter +1, go to FAULT.
- RUN, `stall`=0, otherwise: PC <= selected next PC, counter +1.
- HALT and FAULT: sticky until `rst_n`. PC, counter and state frozen. All inputs ignored.
- Counter wraps from 32'hFFFF_FFFF to 0 with no flag.

## Timing

- Reset (asynchronous on `rst_n` low, takes effect immediately):
  - `pc` = RESET_PC, `instr_count` = 0, `halted` = 0, `fault` = 0, state RUN.
  - `pc_plus4` = RESET_PC+4.
- Release of `rst_n` is synchronised by the system. First update at the first rising edge with `rst_n` high.
- Fetch is combinational: `instruction` is valid in the same cycle as `pc`. Next-PC decision is made from same-cycle inputs and registered on the rising edge: one instruction per cycle.
- `halted` and `fault` are decoded from the registered state. They assert in the cycle after the `syscall` or faulting instruction's edge.
- `stall` is sampled at the edge. A stall asserted in the same cycle as a `syscall` delays the halt until the first unstalled cycle.
- Reset asserted mid-operation in any state aborts immediately to reset values. No pending update completes.

## Test plan

- Sequential fetch: reset with RESET_PC=0, feed non-control words for 4 cycles -> `pc` 0,4,8,12,16; `instr_count`=4; `pc_plus4`=20.
- Branch: at `pc`=8, `instruction[15:0]`=16'hFFFE, `branch`=1 -> next `pc`=4. Repeat with imm 16'h0003 -> `pc`=24.
- Priority: at `pc`=0, `jr`=1 with `rs_data`=32'h40, `jump`=1, `branch`=1 -> `pc`=32'h40. Then `jump`=1, `instruction[25:0]`=26'h10 -> `pc`=32'h40.
- Fault:
  - `jr`=1 with `rs_data`=32'h42 -> `pc` holds, `fault`=1 next cycle, count incremented, later inputs ignored.
  - After reset, `jr` to 32'h400 (MEM_WORDS=256) -> same result.
- Halt with stall: `instruction`=32'h0000_000C with `stall`=1 for 2 cycles -> no change. `stall`=0 -> `halted`=1, `pc` unchanged, count +1. `branch` pulses after that have no effect.
- Async reset: assert `rst_n`=0 between edges while in FAULT -> `pc`=RESET_PC, `fault`=0, `instr_count`=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: controls and instruction word in, PC, status and retire count out.
interface pc_fetch_if;
  logic [31:0] instruction;
  logic        branch;
  logic        jump;
  logic        jr;
  logic [31:0] rs_data;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  // Datapath / control side that feeds the fetch stage
  modport master (
    output instruction, branch, jump, jr, rs_data, stall,
    input  pc, pc_plus4, halted, fault, instr_count
  );

  // Fetch stage itself
  modport slave (
    input  instruction, branch, jump, jr, rs_data, stall,
    output pc, pc_plus4, halted, fault, instr_count
  );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and next-PC sequencing for the single-cycle MIPS datapath.
// Halts on syscall, faults on misaligned or out-of-range targets, counts retired
// instructions. HALT and FAULT are sticky until reset.
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256
) (
  input logic       clk,
  input logic       rst_n,
  pc_fetch_if.slave bus
);

  localparam logic [31:0] SyscallWord = 32'h0000_000C;
  // One bit wider than the PC so MEM_WORDS*4 cannot overflow
  localparam logic [32:0] PcLimit     = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] count_q;

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] jmp_pc;
  logic [31:0] next_pc;
  logic        syscall;
  logic        illegal;

  assign seq_pc  = pc_q + 32'd4;
  assign br_pc   = seq_pc + {{14{bus.instruction[15]}}, bus.instruction[15:0], 2'b00};
  assign jmp_pc  = {seq_pc[31:28], bus.instruction[25:0], 2'b00};
  assign syscall = (bus.instruction == SyscallWord);

  // Next-PC select: jr over jump over branch over sequential
  always_comb begin
    next_pc = seq_pc;
    if (bus.jr) begin
      next_pc = bus.rs_data;
    end else if (bus.jump) begin
      next_pc = jmp_pc;
    end else if (bus.branch) begin
      next_pc = br_pc;
    end
  end

  assign illegal = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= PcLimit);

  // State, PC and retire counter; every unstalled RUN cycle retires one instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else if (state_q == StRun && !bus.stall) begin
      count_q <= count_q + 32'd1;
      if (syscall) begin
        state_q <= StHalt;
      end else if (illegal) begin
        state_q <= StFault;
      end else begin
        pc_q <= next_pc;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = seq_pc;
  assign bus.instr_count = count_q;
  assign bus.halted      = (state_q == StHalt);
  assign bus.fault       = (state_q == StFault);

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: expected {pc, instr_count, halted, fault}
// is queued when a cycle's stimulus is driven and compared after the edge.
module tb_pc_fetch;

  localparam logic [31:0] NOP     = 32'h2008_0001;
  localparam logic [31:0] SYSCALL = 32'h0000_000C;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  logic [65:0] sb[$];
  logic [65:0] e;
  logic [65:0] got;

  pc_fetch_if bus ();

  pc_fetch #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(256)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] obs();
    return {bus.pc, bus.instr_count, bus.halted, bus.fault};
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge state, advance past the edge
  task automatic step(input logic [31:0] ins, input logic br, input logic jp, input logic jrr,
                      input logic [31:0] rs, input logic stl, input logic [31:0] e_pc,
                      input logic [31:0] e_cnt, input logic e_h, input logic e_f);
    bus.instruction = ins;
    bus.branch      = br;
    bus.jump        = jp;
    bus.jr          = jrr;
    bus.rs_data     = rs;
    bus.stall       = stl;
    sb.push_back({e_pc, e_cnt, e_h, e_f});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.instruction = NOP;
    bus.branch = 1'b0;
    bus.jump = 1'b0;
    bus.jr = 1'b0;
    bus.rs_data = '0;
    bus.stall = 1'b0;
    #3;
    tests++;
    if (obs() !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", obs(), {32'h0, 32'h0, 1'b0, 1'b0});
    end
    tests++;
    if (bus.pc_plus4 !== 32'd4) begin
      fails++;
      $display("FAIL reset_pc_plus4: got %h expected %h", bus.pc_plus4, 32'd4);
    end
    // An edge while reset is held must not update anything
    step(NOP, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL reset_hold: got %h expected %h", got, e); end
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      step(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'(4 * i), 32'(i), 1'b0, 1'b0);
      e = sb.pop_front(); got = obs(); tests++;
      if (got !== e) begin fails++; $display("FAIL seq_%0d: got %h expected %h", i, got, e); end
    end
    tests++;
    if (bus.pc_plus4 !== 32'd20) begin
      fails++;
      $display("FAIL seq_pc_plus4: got %h expected %h", bus.pc_plus4, 32'd20);
    end
  endtask

  task automatic test_branch();
    do_reset();
    step(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd4, 32'd1, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd8, 32'd2, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); got = obs();
    end
    // Backward: 8 + 4 - 8 = 4
    step(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'd4, 32'd3, 1'b0, 1'b0);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL branch_back: got %h expected %h", got, e); end
    step(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd8, 32'd4, 1'b0, 1'b0);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL branch_seq: got %h expected %h", got, e); end
    // Forward: 8 + 4 + 12 = 24
    step(32'h1000_0003, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'd24, 32'd5, 1'b0, 1'b0);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL branch_fwd: got %h expected %h", got, e); end
  endtask

  task automatic test_priority();
    do_reset();
    step(32'h0800_0001, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h40, 32'd1, 1'b0, 1'b0);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL prio_jr: got %h expected %h", got, e); end
    step(32'h0800_0010, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h40, 32'd2, 1'b0, 1'b0);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL prio_jump: got %h expected %h", got, e); end
    // Jump target 0x10 wins over branch target 0x44 + 0x10
    step(32'h0800_0004, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h10, 32'd3, 1'b0, 1'b0);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL prio_jump_branch: got %h expected %h", got, e); end
  endtask

  task automatic test_fault_misaligned();
    do_reset();
    step(NOP, 1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 32'h0, 32'd1, 1'b0, 1'b1);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL fault_misalign: got %h expected %h", got, e); end
    step(32'h1000_0003, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd1, 1'b0, 1'b1);
    step(SYSCALL, 1'b0, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'd1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); got = obs();
      if (i == 1) begin
        tests++;
        if (got !== e) begin fails++; $display("FAIL fault_sticky: got %h expected %h", got, e); end
      end
    end
  endtask

  task automatic test_fault_range();
    do_reset();
    step(NOP, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 32'd1, 1'b0, 1'b1);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL fault_range: got %h expected %h", got, e); end
    // Last legal word, then sequential step off the end of memory
    do_reset();
    step(NOP, 1'b0, 1'b0, 1'b1, 32'h3FC, 1'b0, 32'h3FC, 32'd1, 1'b0, 1'b0);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL last_legal: got %h expected %h", got, e); end
    step(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h3FC, 32'd2, 1'b0, 1'b1);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL seq_past_end: got %h expected %h", got, e); end
  endtask

  task automatic test_halt_stall();
    do_reset();
    step(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'd0, 1'b0, 1'b0);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL stall_nop: got %h expected %h", got, e); end
    for (int i = 0; i < 2; i++) begin
      step(SYSCALL, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'd0, 1'b0, 1'b0);
      e = sb.pop_front(); got = obs(); tests++;
      if (got !== e) begin fails++; $display("FAIL stall_syscall_%0d: got %h expected %h", i, got, e); end
    end
    step(SYSCALL, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd1, 1'b1, 1'b0);
    e = sb.pop_front(); got = obs(); tests++;
    if (got !== e) begin fails++; $display("FAIL halt: got %h expected %h", got, e); end
    for (int i = 0; i < 2; i++) begin
      step(32'h1000_0003, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd1, 1'b1, 1'b0);
      e = sb.pop_front(); got = obs(); tests++;
      if (got !== e) begin fails++; $display("FAIL halt_sticky_%0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd4, 32'd1, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd8, 32'd2, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 32'd8, 32'd3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front(); got = obs();
      if (i == 2) begin
        tests++;
        if (got !== e) begin fails++; $display("FAIL pre_async_fault: got %h expected %h", got, e); end
      end
    end
    // Mid-cycle: no edge between assertion and the check
    #2;
    rst_n = 1'b0;
    #1;
    got = obs();
    tests++;
    if (got !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got %h expected %h", got, {32'h0, 32'h0, 1'b0, 1'b0});
    end
    tests++;
    if (bus.pc_plus4 !== 32'd4) begin
      fails++;
      $display("FAIL async_pc_plus4: got %h expected %h", bus.pc_plus4, 32'd4);
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_fault_misaligned();
    test_fault_range();
    test_halt_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
